// File: rtl/rr_mux_if.sv
// Bundle between eight requesters, the shared 8:1 mux scheduler and its downstream consumer.
// The master side is the requesters plus consumer; the slave side is the scheduler.
interface rr_mux_if #(
  parameter int unsigned DW = 8
);
  logic [7:0]      req;
  logic [8*DW-1:0] din;
  logic            out_ready;
  logic            out_valid;
  logic [DW-1:0]   out_data;
  logic [2:0]      sel;
  logic [7:0]      grant;
  logic            busy;

  modport master (
    output req,
    output din,
    output out_ready,
    input  out_valid,
    input  out_data,
    input  sel,
    input  grant,
    input  busy
  );

  modport slave (
    input  req,
    input  din,
    input  out_ready,
    output out_valid,
    output out_data,
    output sel,
    output grant,
    output busy
  );
endinterface

// File: rtl/rr_mux_scheduler.sv
// Round-robin arbiter owning the select of a shared 8:1 data mux. A grant lasts at most
// MAX_HOLD accepted words, or ends as soon as the granted requester drops its request.
module rr_mux_scheduler #(
  parameter int unsigned DW       = 8,
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic       clk,
  input  logic       rst,
  rr_mux_if.slave    bus
);

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  state_e     state_q, state_d;
  logic [2:0] ptr_q, ptr_d;
  logic [2:0] sel_q, sel_d;
  logic [7:0] grant_q, grant_d;
  logic [3:0] hold_q, hold_d;

  logic [DW-1:0] lanes [8];
  logic [2:0]    pick;
  logic [2:0]    cand;
  logic          found;
  logic          sel_req;
  logic          xfer;
  logic          last_xfer;
  logic          release_now;

  for (genvar i = 0; i < 8; i++) begin : g_lanes
    assign lanes[i] = bus.din[i*DW +: DW];
  end

  // Cyclic first-one search starting at ptr_q.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int k = 0; k < 8; k++) begin
      cand = ptr_q + 3'(k);
      if (!found && bus.req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  assign sel_req     = bus.req[sel_q];
  assign xfer        = (state_q == StGrant) && sel_req && bus.out_ready;
  assign last_xfer   = xfer && (hold_q == 4'(MAX_HOLD - 1));
  assign release_now = (state_q == StGrant) && (!sel_req || last_xfer);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    grant_d = grant_q;
    hold_d  = hold_q;
    unique case (state_q)
      StIdle: begin
        if (found) begin
          state_d = StGrant;
          sel_d   = pick;
          grant_d = 8'b1 << pick;
          hold_d  = '0;
        end
      end
      StGrant: begin
        if (release_now) begin
          // sel is deliberately left at the last granted index.
          state_d = StIdle;
          ptr_d   = sel_q + 3'd1;
          grant_d = '0;
          hold_d  = '0;
        end else if (xfer) begin
          hold_d = hold_q + 4'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      sel_q   <= '0;
      grant_q <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      grant_q <= grant_d;
      hold_q  <= hold_d;
    end
  end

  // out_valid follows the live request so an abandon is visible in the same cycle.
  always_comb begin
    bus.out_valid = 1'b0;
    bus.out_data  = '0;
    if (state_q == StGrant && sel_req) begin
      bus.out_valid = 1'b1;
      bus.out_data  = lanes[sel_q];
    end
  end

  assign bus.sel   = sel_q;
  assign bus.grant = grant_q;
  assign bus.busy  = (state_q == StGrant);

  a_grant_onehot0 : assert property (@(posedge clk) disable iff (rst) $onehot0(grant_q));
  a_grant_busy    : assert property (@(posedge clk) disable iff (rst)
                                     ((grant_q == '0) == (state_q == StIdle)));
  a_hold_bound    : assert property (@(posedge clk) disable iff (rst)
                                     (hold_q < 4'(MAX_HOLD)));

endmodule

// File: tb/tb_rr_mux_scheduler.sv
// Directed bench for rr_mux_scheduler (DW=8, MAX_HOLD=4). Observation vector is
// {busy, grant, sel, out_valid, out_data}.
module tb_rr_mux_scheduler;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rr_mux_if #(.DW(8)) bus ();

  rr_mux_scheduler #(.DW(8), .MAX_HOLD(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  logic [20:0] obs;
  assign obs = {bus.busy, bus.grant, bus.sel, bus.out_valid, bus.out_data};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lanes();
    for (int i = 0; i < 8; i++) bus.din[i*8 +: 8] = 8'h10 + 8'(i);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req = '0;
    bus.out_ready = 1'b0;
    set_lanes();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [20:0] e;
    rst = 1'b1;
    bus.req = 8'hFF;
    bus.out_ready = 1'b1;
    set_lanes();
    step();
    step();
    e = {1'b0, 8'h00, 3'd0, 1'b0, 8'h00};
    n_vec++;
    if (obs !== e) begin
      $display("FAIL reset_state got %h want %h", obs, e);
      n_err++;
    end
    rst = 1'b0;
    step();
    e = {1'b1, 8'h01, 3'd0, 1'b1, 8'h10};
    n_vec++;
    if (obs !== e) begin
      $display("FAIL first_grant got %h want %h", obs, e);
      n_err++;
    end
  endtask

  task automatic test_single();
    logic [20:0] e;
    do_reset();
    bus.din[24 +: 8] = 8'hA5;
    bus.req = 8'h08;
    bus.out_ready = 1'b1;
    step();
    e = {1'b1, 8'h08, 3'd3, 1'b1, 8'hA5};
    for (int b = 0; b < 4; b++) begin
      n_vec++;
      if (obs !== e) begin
        $display("FAIL single_xfer%0d got %h want %h", b, obs, e);
        n_err++;
      end
      step();
    end
    e = {1'b0, 8'h00, 3'd3, 1'b0, 8'h00};
    n_vec++;
    if (obs !== e) begin
      $display("FAIL single_bubble got %h want %h", obs, e);
      n_err++;
    end
    step();
    e = {1'b1, 8'h08, 3'd3, 1'b1, 8'hA5};
    n_vec++;
    if (obs !== e) begin
      $display("FAIL single_regrant got %h want %h", obs, e);
      n_err++;
    end
  endtask

  task automatic test_all_requesting();
    logic [20:0] e;
    int s;
    do_reset();
    bus.req = 8'hFF;
    bus.out_ready = 1'b1;
    step();
    for (int g = 0; g < 9; g++) begin
      s = g % 8;
      e = {1'b1, 8'(1 << s), 3'(s), 1'b1, 8'h10 + 8'(s)};
      for (int b = 0; b < 4; b++) begin
        n_vec++;
        if (obs !== e) begin
          $display("FAIL all_g%0d_b%0d got %h want %h", g, b, obs, e);
          n_err++;
        end
        step();
      end
      e = {1'b0, 8'h00, 3'(s), 1'b0, 8'h00};
      n_vec++;
      if (obs !== e) begin
        $display("FAIL all_bubble%0d got %h want %h", g, obs, e);
        n_err++;
      end
      step();
    end
  endtask

  task automatic test_backpressure();
    logic [20:0] e;
    logic [9:0]  pat;
    pat = 10'b1001001001;
    do_reset();
    bus.din[0 +: 8] = 8'h5A;
    bus.req = 8'h01;
    step();
    e = {1'b1, 8'h01, 3'd0, 1'b1, 8'h5A};
    for (int c = 0; c < 10; c++) begin
      bus.out_ready = pat[c];
      #1;
      n_vec++;
      if (obs !== e) begin
        $display("FAIL bp_cycle%0d got %h want %h", c, obs, e);
        n_err++;
      end
      step();
    end
    e = {1'b0, 8'h00, 3'd0, 1'b0, 8'h00};
    n_vec++;
    if (obs !== e) begin
      $display("FAIL bp_release got %h want %h", obs, e);
      n_err++;
    end
  endtask

  task automatic test_abandon();
    logic [20:0] e;
    do_reset();
    bus.req = 8'h60;
    bus.out_ready = 1'b1;
    step();
    e = {1'b1, 8'h20, 3'd5, 1'b1, 8'h15};
    for (int b = 0; b < 2; b++) begin
      n_vec++;
      if (obs !== e) begin
        $display("FAIL abandon_xfer%0d got %h want %h", b, obs, e);
        n_err++;
      end
      step();
    end
    bus.req = 8'h40;
    #1;
    e = {1'b1, 8'h20, 3'd5, 1'b0, 8'h00};
    n_vec++;
    if (obs !== e) begin
      $display("FAIL abandon_cycle got %h want %h", obs, e);
      n_err++;
    end
    step();
    e = {1'b0, 8'h00, 3'd5, 1'b0, 8'h00};
    n_vec++;
    if (obs !== e) begin
      $display("FAIL abandon_release got %h want %h", obs, e);
      n_err++;
    end
    step();
    e = {1'b1, 8'h40, 3'd6, 1'b1, 8'h16};
    n_vec++;
    if (obs !== e) begin
      $display("FAIL abandon_next got %h want %h", obs, e);
      n_err++;
    end
  endtask

  task automatic test_wrap_reset();
    logic [20:0] e;
    do_reset();
    bus.req = 8'h40;
    step();
    bus.req = 8'h00;
    step();
    bus.req = 8'h81;
    bus.out_ready = 1'b1;
    step();
    e = {1'b1, 8'h80, 3'd7, 1'b1, 8'h17};
    n_vec++;
    if (obs !== e) begin
      $display("FAIL wrap_grant7 got %h want %h", obs, e);
      n_err++;
    end
    for (int b = 0; b < 4; b++) step();
    e = {1'b0, 8'h00, 3'd7, 1'b0, 8'h00};
    n_vec++;
    if (obs !== e) begin
      $display("FAIL wrap_bubble got %h want %h", obs, e);
      n_err++;
    end
    step();
    e = {1'b1, 8'h01, 3'd0, 1'b1, 8'h10};
    n_vec++;
    if (obs !== e) begin
      $display("FAIL wrap_grant0 got %h want %h", obs, e);
      n_err++;
    end
    step();
    rst = 1'b1;
    step();
    e = {1'b0, 8'h00, 3'd0, 1'b0, 8'h00};
    n_vec++;
    if (obs !== e) begin
      $display("FAIL midop_reset got %h want %h", obs, e);
      n_err++;
    end
    rst = 1'b0;
    bus.req = 8'h03;
    step();
    e = {1'b1, 8'h01, 3'd0, 1'b1, 8'h10};
    n_vec++;
    if (obs !== e) begin
      $display("FAIL post_reset_ptr got %h want %h", obs, e);
      n_err++;
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.req = '0;
    bus.din = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_single();
    test_all_requesting();
    test_backpressure();
    test_abandon();
    test_wrap_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rr_mux_scheduler.md
Name: rr_mux_scheduler

Overview:
Round-robin scheduler that shares one 8:1 data mux between eight requesters. It arbitrates among the request lines and drives the mux select. It presents the selected requester's data word on a valid/ready output channel and releases the grant after a bounded burst. It sits in front of the downstream consumer and owns the select of the shared 8:1 mux datapath.

Parameters:
DW, 8, data width per requester lane
MAX_HOLD, 4, maximum transfers per grant before forced release (legal range 1..15)

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous, active-high reset
req  input  8  per-requester request, level-sensitive; bit i = requester i
din  input  8*DW  packed lane data; lane i = din[i*DW +: DW]
out_ready  input  1  downstream accepts a word this cycle
out_valid  output  1  out_data valid this cycle
out_data  output  DW  word from the granted lane
sel  output  3  mux select = index of the granted requester
grant  output  8  one-hot grant; all zero when idle
busy  output  1  high while in GRANT state

Behaviour:
- Reset, synchronous, active-high; takes effect at the next clk edge with rst=1. It overrides all other inputs.
  - Outputs after reset: state=IDLE, grant=0, sel=0, busy=0, out_valid=0, out_data=0.
  - Internal state after reset: ptr=0, hold_cnt=0.
- Two-state FSM: IDLE, GRANT.
- IDLE:
  - If req==0, stay in IDLE.
  - Otherwise pick the first i with req[i]=1, searching cyclically from ptr: ptr, ptr+1, …, 7, 0, …, ptr-1.
  - Register sel=i and grant=1<<i, clear hold_cnt, and go to GRANT.
  - Latency: req rising at edge t gives grant/sel/busy valid after edge t+1. There is no combinational req->grant path.
- GRANT:
  - out_valid = req[sel]. This is combinational from req; grant is registered.
  - out_data = lane[sel] when out_valid=1; otherwise 0.
  - A transfer occurs in any cycle where out_valid & out_ready. Each transfer increments hold_cnt.
- Release from GRANT to IDLE happens at the edge ending a cycle in which either:
  - (a) req[sel]=0, which is an abandon with no transfer that cycle; or
  - (b) a transfer occurs with hold_cnt==MAX_HOLD-1.
- On release:
  - ptr=(sel+1) mod 8, with wrap 7→0.
  - grant=0, busy=0, hold_cnt=0.
  - sel keeps its last value.
- There is one idle bubble cycle between consecutive grants. Peak throughput is MAX_HOLD words per MAX_HOLD+1 cycles.
- If out_ready=0, the grant is held indefinitely, hold_cnt is frozen, and out_data stays stable while req[sel] is held.
- Requests from non-granted requesters do not affect the current grant, sel, or out_data.
- Fairness: with all req high, grants go 0,1,2,…,7,0,…. A requester waits at most 7 grants.
- Reset mid-GRANT: the in-flight burst is dropped and no release bookkeeping happens. The next arbitration starts from requester 0.
- Invariant: grant is one-hot or zero; grant==0 if and only if busy==0.

Test Plan:
- Reset: hold rst=1 for 2 cycles with req=8'hFF -> grant=0, sel=0, busy=0, out_valid=0, out_data=0. First grant after rst drops is requester 0, one cycle later.
- Single requester: req=8'h08, lane3=8'hA5, out_ready=1, MAX_HOLD=4.
  - sel=3 one cycle after req.
  - Exactly 4 transfers of 8'hA5, then one bubble cycle, then re-grant to 3 (ptr=4 wraps through the search).
- All requesting: req=8'hFF, lane i=8'h10+i, out_ready=1.
  - Grant order is 0,1,…,7,0.
  - Each burst carries 4 transfers.
  - Output sequence is 4×8'h10, 4×8'h11, …
- Backpressure: req=8'h01, out_ready toggling 1,0,0,1,…
  - hold_cnt advances only on ready=1 cycles.
  - Release occurs after the 4th accepted word.
  - out_data is stable during stalls.
- Abandon: grant to requester 5, then drop req[5] after 2 transfers while req[6]=1.
  - Release at that edge.
  - Next grant goes to 6.
  - No transfer in the abandon cycle.
- Wrap and reset mid-op:
  - With ptr=7 and req=8'h81, grant goes to 7, then 0.
  - Assert rst during the grant to 0 -> next edge gives all reset values; ptr returns to 0.
